// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding fetch, DEPTH-entry word/PC FIFO, redirect flush.
// Optional same-cycle response bypass into an empty FIFO is enabled by defining PREFETCH_BYPASS_EN.
module instr_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [63:0]                imem_addr,
    input  logic                       imem_valid,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [63:0]                redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_instr,
    output logic [63:0]                deq_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   req_pc_q, req_pc_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_q [DEPTH];
    logic [63:0]   pc_q [DEPTH];

    logic enq;
    logic fifo_deq;
    logic bypass;
    logic not_empty;

    assign not_empty = (count_q != '0);
    assign fifo_deq  = not_empty && deq_ready && !redirect;

`ifdef PREFETCH_BYPASS_EN
    assign bypass = (state_q == S_WAIT) && imem_valid && !redirect
                    && deq_ready && !not_empty && !reset;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        imem_req   = 1'b0;
        enq        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (!reset && count_q < FULL) begin
                    imem_req = 1'b1;
                    req_pc_d = fetch_pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response arriving with the redirect closes the request.
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_valid ? S_IDLE : S_DISCARD;
                end else if (imem_valid) begin
                    fetch_pc_d = req_pc_q + PC_STEP;
                    state_d    = S_IDLE;
                    enq        = !bypass && !reset;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (imem_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (fifo_deq) head_d = head_q + AW'(1);
            if (enq)      tail_d = tail_q + AW'(1);
            count_d = count_q + CW'(enq) - CW'(fifo_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_q[tail_q] <= imem_rdata;
            pc_q[tail_q]    <= req_pc_q;
        end
    end

    assign imem_addr = imem_req ? fetch_pc_q : '0;
    assign occupancy = count_q;
    assign deq_valid = not_empty || bypass;

    always_comb begin
        deq_instr = '0;
        deq_pc    = '0;
        if (bypass) begin
            deq_instr = imem_rdata;
            deq_pc    = req_pc_q;
        end else if (not_empty) begin
            deq_instr = instr_q[head_q];
            deq_pc    = pc_q[head_q];
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with a latency-configurable memory responder.
// Bypass expectations follow PREFETCH_BYPASS_EN.
module tb_instr_prefetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_instr;
    logic [63:0] deq_pc;
    logic [2:0]  occupancy;

    int errors = 0;
    int checks = 0;
    int lat = 1;

    logic [63:0] req_log[$];
    logic [63:0] dpc_log[$];
    logic [31:0] dins_log[$];

    instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(64'd0), .PC_STEP(64'd4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_instr(deq_instr), .deq_pc(deq_pc),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    // Memory responder at +2, handshake monitor at +3 after each rising edge.
    initial begin : responder
        bit          pend;
        int          cnt;
        logic [63:0] pa;
        pend = 0; cnt = 0; pa = '0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            imem_valid = 1'b0;
            if (reset) begin
                pend = 0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = ins_of(pa);
                    pend = 0;
                end
            end
            if (imem_req) begin
                pend = 1;
                cnt  = lat;
                pa   = imem_addr;
                req_log.push_back(imem_addr);
            end
            #1;
            if (deq_valid && deq_ready && !redirect && !reset) begin
                dpc_log.push_back(deq_pc);
                dins_log.push_back(deq_instr);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        deq_ready = 1'b0;
        repeat (3) step();
        req_log.delete();
        dpc_log.delete();
        dins_log.delete();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        lat = 1;
        reset = 1'b1;
        redirect = 1'b1;
        redirect_pc = 64'h500;
        deq_ready = 1'b1;
        repeat (3) step();
        #3;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 64'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b want 0", deq_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        checks++; if (deq_pc !== 64'd0) begin errors++; $display("FAIL rst_pc: got %h want 0", deq_pc); end
        checks++; if (deq_instr !== 32'd0) begin errors++; $display("FAIL rst_ins: got %h want 0", deq_instr); end
        step();
        reset = 1'b0;
        redirect = 1'b0;
        #3;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'd0) begin errors++; $display("FAIL rst_first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_run();
        lat = 1;
        do_reset();
        deq_ready = 1'b1;
        repeat (12) step();
        #3;
        for (int i = 0; i < 4; i++) begin
            logic [63:0] e;
            e = 64'(4 * i);
            checks++; if ((req_log.size() > i ? req_log[i] : 64'hx) !== e) begin errors++; $display("FAIL run_addr%0d: got %h want %h", i, (req_log.size() > i ? req_log[i] : 64'hx), e); end
            checks++; if ((dpc_log.size() > i ? dpc_log[i] : 64'hx) !== e) begin errors++; $display("FAIL run_pc%0d: got %h want %h", i, (dpc_log.size() > i ? dpc_log[i] : 64'hx), e); end
            checks++; if ((dins_log.size() > i ? dins_log[i] : 32'hx) !== ins_of(e)) begin errors++; $display("FAIL run_ins%0d: got %h want %h", i, (dins_log.size() > i ? dins_log[i] : 32'hx), ins_of(e)); end
        end
    endtask

    task automatic test_full();
        lat = 1;
        do_reset();
        deq_ready = 1'b0;
        repeat (12) step();
        #3;
        checks++; if (req_log.size() !== 4) begin errors++; $display("FAIL full_nreq: got %0d want 4", req_log.size()); end
        checks++; if ((req_log.size() > 3 ? req_log[3] : 64'hx) !== 64'd12) begin errors++; $display("FAIL full_last: got %h want c", (req_log.size() > 3 ? req_log[3] : 64'hx)); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d want 4", occupancy); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b want 0", imem_req); end
        checks++; if (deq_pc !== 64'd0 || deq_instr !== ins_of(64'd0)) begin errors++; $display("FAIL full_head: got %h/%h want 0/%h", deq_pc, deq_instr, ins_of(64'd0)); end
        step();
        deq_ready = 1'b1;
        #3;
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 64'd0) begin errors++; $display("FAIL full_deq: got v=%b pc=%h want v=1 pc=0", deq_valid, deq_pc); end
        step();
        deq_ready = 1'b0;
        repeat (4) step();
        #3;
        checks++; if ((req_log.size() > 4 ? req_log[4] : 64'hx) !== 64'd16) begin errors++; $display("FAIL full_next: got %h want 10", (req_log.size() > 4 ? req_log[4] : 64'hx)); end
        checks++; if (req_log.size() !== 5) begin errors++; $display("FAIL full_nreq2: got %0d want 5", req_log.size()); end
        checks++; if (occupancy !== 3'd4 || deq_pc !== 64'd4) begin errors++; $display("FAIL full_refill: got occ=%0d pc=%h want 4/4", occupancy, deq_pc); end
    endtask

    task automatic test_redirect_inflight();
        bit found;
        lat = 3;
        do_reset();
        deq_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            #3;
            if (imem_req && imem_addr == 64'd8) found = 1;
            else step();
        end
        checks++; if (!found) begin errors++; $display("FAIL rdi_find: got none want req 8"); end
        step();
        redirect = 1'b1;
        redirect_pc = 64'h100;
        #3;
        step();
        redirect = 1'b0;
        #3;
        checks++; if (occupancy !== 3'd0 || deq_valid !== 1'b0) begin errors++; $display("FAIL rdi_flush: got occ=%0d v=%b want 0/0", occupancy, deq_valid); end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            #3;
            if (deq_valid) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rdi_timeout: got no deq_valid want 1"); end
        checks++; if (deq_pc !== 64'h100 || deq_instr !== ins_of(64'h100)) begin errors++; $display("FAIL rdi_head: got %h/%h want 100/%h", deq_pc, deq_instr, ins_of(64'h100)); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL rdi_occ: got %0d want 1", occupancy); end
        checks++; if ((req_log.size() > 3 ? req_log[3] : 64'hx) !== 64'h100) begin errors++; $display("FAIL rdi_addr: got %h want 100", (req_log.size() > 3 ? req_log[3] : 64'hx)); end
    endtask

    task automatic test_redirect_valid();
        bit found;
        lat = 1;
        do_reset();
        deq_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            #3;
            if (occupancy == 3'd2 && imem_req) found = 1;
            else step();
        end
        checks++; if (!found) begin errors++; $display("FAIL rdv_find: got none want occ2+req"); end
        step();
        redirect = 1'b1;
        redirect_pc = 64'h200;
        deq_ready = 1'b1;
        #3;
        step();
        redirect = 1'b0;
        deq_ready = 1'b0;
        #3;
        checks++; if (occupancy !== 3'd0 || deq_valid !== 1'b0) begin errors++; $display("FAIL rdv_flush: got occ=%0d v=%b want 0/0", occupancy, deq_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin errors++; $display("FAIL rdv_req: got req=%b addr=%h want 1/200", imem_req, imem_addr); end

        do_reset();
        deq_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            #3;
            if (occupancy == 3'd2 && imem_req) found = 1;
            else step();
        end
        step();
        deq_ready = 1'b1;
        #3;
        step();
        deq_ready = 1'b0;
        #3;
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL enqdeq_occ: got %0d want 2", occupancy); end
        checks++; if (deq_pc !== 64'd4 || deq_instr !== ins_of(64'd4)) begin errors++; $display("FAIL enqdeq_head: got %h/%h want 4/%h", deq_pc, deq_instr, ins_of(64'd4)); end
    endtask

    task automatic test_wrap();
        lat = 1;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        deq_ready = 1'b1;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 40; i++) begin
            deq_ready = (i % 3 != 2);
            step();
        end
        deq_ready = 1'b0;
        #3;
        checks++; if ((req_log.size() > 0 ? req_log[0] : 64'hx) !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_a0: got %h want fffffffffffffffc", (req_log.size() > 0 ? req_log[0] : 64'hx)); end
        checks++; if ((req_log.size() > 1 ? req_log[1] : 64'hx) !== 64'd0) begin errors++; $display("FAIL wrap_a1: got %h want 0", (req_log.size() > 1 ? req_log[1] : 64'hx)); end
        for (int i = 0; i < 10; i++) begin
            logic [63:0] e;
            e = 64'hFFFF_FFFF_FFFF_FFFC + 64'(4 * i);
            checks++; if ((dpc_log.size() > i ? dpc_log[i] : 64'hx) !== e) begin errors++; $display("FAIL wrap_pc%0d: got %h want %h", i, (dpc_log.size() > i ? dpc_log[i] : 64'hx), e); end
            checks++; if ((dins_log.size() > i ? dins_log[i] : 32'hx) !== ins_of(e)) begin errors++; $display("FAIL wrap_ins%0d: got %h want %h", i, (dins_log.size() > i ? dins_log[i] : 32'hx), ins_of(e)); end
        end
    endtask

    task automatic test_bypass();
        lat = 1;
        do_reset();
        deq_ready = 1'b1;
        #3;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'd0) begin errors++; $display("FAIL byp_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        step();
        #3;
`ifdef PREFETCH_BYPASS_EN
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 64'd0 || deq_instr !== ins_of(64'd0)) begin errors++; $display("FAIL byp_same: got v=%b pc=%h ins=%h want 1/0/%h", deq_valid, deq_pc, deq_instr, ins_of(64'd0)); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL byp_occ: got %0d want 0", occupancy); end
        step();
        #3;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL byp_occ2: got %0d want 0", occupancy); end
`else
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL nbyp_same: got %b want 0", deq_valid); end
        step();
        #3;
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 64'd0 || deq_instr !== ins_of(64'd0)) begin errors++; $display("FAIL nbyp_next: got v=%b pc=%h ins=%h want 1/0/%h", deq_valid, deq_pc, deq_instr, ins_of(64'd0)); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL nbyp_occ: got %0d want 1", occupancy); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        deq_ready = 1'b0;
        test_reset();
        test_run();
        test_full();
        test_redirect_inflight();
        test_redirect_valid();
        test_wrap();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
